// File: rtl/uart_seq_pkg.sv
// Shared types and helpers for the UART <-> AND_com frame sequencer.
// UART_SEQ_CHECKSUM_EN adds the CHK state (XOR checksum byte after the operand).
package uart_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
`ifdef UART_SEQ_CHECKSUM_EN
      S_CHK,
`endif
      S_RUN,
      S_WAIT,
      S_TXLD,
      S_TXWT
   } state_t;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_and_sequencer_if.sv
// Handshake bundle between the sequencer, the UART pair and AND_com.
// master = sequencer side, slave = UART/AND_com side.
interface uart_and_sequencer_if #(
   parameter int M = 8,
   parameter int R = 8
);
   logic         rx_done;
   logic [7:0]   rx_data;
   logic         rx_en;
   logic [7:0]   tx_data;
   logic         tx_en;
   logic         tx_done;
   logic         and_enable;
   logic         and_done;
   logic [R-1:0] result;
   logic [M-1:0] operand;
   logic         busy;
   logic         err;

   modport master (
      input  rx_done, rx_data, tx_done, and_done, result,
      output rx_en, tx_data, tx_en, and_enable, operand, busy, err
   );

   modport slave (
      output rx_done, rx_data, tx_done, and_done, result,
      input  rx_en, tx_data, tx_en, and_enable, operand, busy, err
   );
endinterface

// File: rtl/uart_and_sequencer_timeout.sv
// Idle-cycle counter with terminal count; cleared whenever clr or !en.
// Holds at the terminal value until the sequencer leaves the timed state.
module seq_timeout
   import uart_seq_pkg::*;
#(
   parameter int LIMIT = 40000
) (
   input  logic clk,
   input  logic Rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = (clog2(LIMIT) < 1) ? 1 : clog2(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n)
         cnt <= '0;
      else if (clr || !en)
         cnt <= '0;
      else if (!tc)
         cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/uart_and_sequencer.sv
// Frame sequencer: RX operand bytes -> AND_com -> TX result bytes, with timeout.
// Define UART_SEQ_CHECKSUM_EN to require an XOR checksum byte after the operand.
module uart_and_sequencer
   import uart_seq_pkg::*;
#(
   parameter int M           = 8,
   parameter int R           = 8,
   parameter int TIMEOUT_CYC = 40000
) (
   input logic                 clk,
   input logic                 Rst_n,
   uart_and_sequencer_if.master bus
);
   localparam int NRX = nbytes(M);
   localparam int NTX = nbytes(R);
   localparam int BW  = clog2(NRX + 1);
   localparam int TW  = clog2(NTX + 1);

   state_t             state;
   logic [8*NRX-1:0]   op_q;
   logic [8*NTX-1:0]   tx_sr;
   logic [BW-1:0]      byte_cnt;
   logic [TW-1:0]      tx_rem;
   logic               tmo_en;
   logic               tmo_clr;
   logic               tmo_tc;

   assign bus.operand = op_q[M-1:0];

`ifdef UART_SEQ_CHECKSUM_EN
   logic [7:0] csum;
   always_comb begin
      csum = '0;
      for (int i = 0; i < NRX; i++)
         csum ^= op_q[8*i +: 8];
   end
   assign tmo_en = (state == S_RECV) || (state == S_CHK) || (state == S_WAIT);
`else
   assign tmo_en = (state == S_RECV) || (state == S_WAIT);
`endif

   // rx_done is meaningless in WAIT_AND, so it must not restart that timer
   assign tmo_clr = bus.rx_done && (state != S_WAIT);

   seq_timeout #(.LIMIT(TIMEOUT_CYC)) u_tmo (
      .clk   (clk),
      .Rst_n (Rst_n),
      .clr   (tmo_clr),
      .en    (tmo_en),
      .tc    (tmo_tc)
   );

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= S_IDLE;
         op_q           <= '0;
         tx_sr          <= '0;
         byte_cnt       <= '0;
         tx_rem         <= '0;
         bus.rx_en      <= 1'b0;
         bus.tx_data    <= '0;
         bus.tx_en      <= 1'b0;
         bus.and_enable <= 1'b0;
         bus.busy       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.tx_en <= 1'b0;
         unique case (state)
            S_IDLE: begin
               bus.rx_en <= 1'b1;
               if (bus.rx_done) begin
                  op_q[7:0] <= bus.rx_data;
                  bus.err   <= 1'b0;
                  bus.busy  <= 1'b1;
                  byte_cnt  <= BW'(1);
                  if (NRX == 1) begin
`ifdef UART_SEQ_CHECKSUM_EN
                     state <= S_CHK;
`else
                     state     <= S_RUN;
                     bus.rx_en <= 1'b0;
`endif
                  end else begin
                     state <= S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (bus.rx_done) begin
                  op_q[8*byte_cnt +: 8] <= bus.rx_data;
                  byte_cnt <= byte_cnt + BW'(1);
                  if (byte_cnt == BW'(NRX - 1)) begin
`ifdef UART_SEQ_CHECKSUM_EN
                     state <= S_CHK;
`else
                     state     <= S_RUN;
                     bus.rx_en <= 1'b0;
`endif
                  end
               end else if (tmo_tc) begin
                  bus.err  <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end
            end
`ifdef UART_SEQ_CHECKSUM_EN
            S_CHK: begin
               if (bus.rx_done) begin
                  bus.rx_en <= 1'b0;
                  if (bus.rx_data == csum) begin
                     state <= S_RUN;
                  end else begin
                     bus.err <= 1'b1;
                     tx_sr   <= (8*NTX)'(ERR_BYTE);
                     tx_rem  <= TW'(1);
                     state   <= S_TXLD;
                  end
               end else if (tmo_tc) begin
                  bus.err  <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end
            end
`endif
            S_RUN: begin
               bus.and_enable <= 1'b1;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.and_done) begin
                  tx_sr          <= (8*NTX)'(bus.result);
                  tx_rem         <= TW'(NTX);
                  bus.and_enable <= 1'b0;
                  state          <= S_TXLD;
               end else if (tmo_tc) begin
                  bus.and_enable <= 1'b0;
                  bus.err        <= 1'b1;
                  bus.busy       <= 1'b0;
                  bus.rx_en      <= 1'b1;
                  state          <= S_IDLE;
               end
            end
            S_TXLD: begin
               bus.tx_data <= tx_sr[7:0];
               tx_sr       <= tx_sr >> 8;
               bus.tx_en   <= 1'b1;
               tx_rem      <= tx_rem - TW'(1);
               state       <= S_TXWT;
            end
            S_TXWT: begin
               if (bus.tx_done) begin
                  if (tx_rem == '0) begin
                     bus.busy  <= 1'b0;
                     bus.rx_en <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     state <= S_TXLD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_and_sequencer.sv
// Scoreboard bench for uart_and_sequencer, M=R=16, short timeout.
// Checksum scenario is compiled in only with UART_SEQ_CHECKSUM_EN.
module tb_uart_and_sequencer;
   import uart_seq_pkg::*;

   localparam int TMO = 40;

   logic clk = 1'b0;
   logic Rst_n = 1'b1;
   always #5 clk = ~clk;

   uart_and_sequencer_if #(.M(16), .R(16)) bus();

   uart_and_sequencer #(.M(16), .R(16), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail = 0;
   int tx_en_cnt = 0;
   int and_cnt = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk) begin
      if (bus.tx_en === 1'b1) tx_en_cnt <= tx_en_cnt + 1;
      if (bus.and_enable === 1'b1) and_cnt <= and_cnt + 1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
      send_byte(b0);
      n_tests++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL first_byte: err=%b busy=%b want err=0 busy=1", bus.err, bus.busy);
      end
      send_byte(b1);
`ifdef UART_SEQ_CHECKSUM_EN
      send_byte(b0 ^ b1);
`endif
   endtask

   task automatic wait_and(output int c);
      c = 0;
      while (bus.and_enable !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic do_and(input int d, input logic [15:0] res);
      repeat (d) @(negedge clk);
      bus.result   = res;
      bus.and_done = 1'b1;
      exp_q.push_back(res[7:0]);
      exp_q.push_back(res[15:8]);
      @(negedge clk);
      n_tests++;
      if (bus.and_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL and_drop: and_enable=%b want 0", bus.and_enable);
      end
      bus.and_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.tx_en !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_latency: tx_en=%b want 1 two cycles after and_done", bus.tx_en);
      end
   endtask

   task automatic serve_tx();
      logic [7:0] want;
      int w;
      while (exp_q.size() > 0) begin
         w = 0;
         while (bus.tx_en !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         want = exp_q.pop_front();
         n_tests++;
         if (bus.tx_en !== 1'b1 || bus.tx_data !== want) begin
            n_fail++;
            $display("FAIL tx_byte: tx_en=%b tx_data=%h want %h", bus.tx_en, bus.tx_data, want);
         end
         @(negedge clk);
         n_tests++;
         if (bus.tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_pulse: tx_en=%b want 0 after one cycle", bus.tx_en);
         end
         repeat (2) @(negedge clk);
         n_tests++;
         if (bus.tx_data !== want) begin
            n_fail++;
            $display("FAIL tx_hold: tx_data=%h want %h", bus.tx_data, want);
         end
         bus.tx_done = 1'b1;
         @(negedge clk);
         bus.tx_done = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] res);
      int c;
      send_frame(b0, b1);
      wait_and(c);
      n_tests++;
      if (c !== 1) begin
         n_fail++;
         $display("FAIL and_latency: got %0d cycles want 2", c + 1);
      end
      n_tests++;
      if (bus.operand !== {b1, b0}) begin
         n_fail++;
         $display("FAIL operand: got %h want %h", bus.operand, {b1, b0});
      end
      do_and(3, res);
      serve_tx();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.rx_en !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_end: busy=%b err=%b rx_en=%b want 0 0 1",
                  bus.busy, bus.err, bus.rx_en);
      end
   endtask

   task automatic test_reset();
      bus.rx_done  = 1'b0;
      bus.rx_data  = '0;
      bus.tx_done  = 1'b0;
      bus.and_done = 1'b0;
      bus.result   = '0;
      #2 Rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({bus.rx_en, bus.tx_en, bus.and_enable, bus.busy, bus.err,
           bus.tx_data, bus.operand} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: rx_en=%b tx_en=%b and_en=%b busy=%b err=%b tx_data=%h op=%h want all 0",
                  bus.rx_en, bus.tx_en, bus.and_enable, bus.busy, bus.err, bus.tx_data, bus.operand);
      end
      Rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.rx_en !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: rx_en=%b busy=%b want 1 0", bus.rx_en, bus.busy);
      end
   endtask

   task automatic test_frame();
      run_frame(8'h34, 8'h12, 16'hBEEF);
   endtask

   task automatic test_rx_timeout();
      int a0;
      a0 = and_cnt;
      send_byte(8'h55);
      repeat (TMO - 2) @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_tmo_early: busy=%b err=%b want 1 0", bus.busy, bus.err);
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.rx_en !== 1'b1 || and_cnt !== a0) begin
         n_fail++;
         $display("FAIL rx_tmo: err=%b busy=%b rx_en=%b and_cycles=%0d want 1 0 1 0",
                  bus.err, bus.busy, bus.rx_en, and_cnt - a0);
      end
      run_frame(8'h78, 8'h56, 16'h1357);
   endtask

   task automatic test_and_timeout();
      int c;
      int t0;
      send_frame(8'hC3, 8'h3C);
      wait_and(c);
      t0 = tx_en_cnt;
      repeat (TMO - 2) @(negedge clk);
      n_tests++;
      if (bus.and_enable !== 1'b1 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL and_tmo_early: and_enable=%b err=%b want 1 0", bus.and_enable, bus.err);
      end
      repeat (5) @(negedge clk);
      n_tests++;
      if (bus.and_enable !== 1'b0 || bus.err !== 1'b1 || bus.busy !== 1'b0 || tx_en_cnt !== t0) begin
         n_fail++;
         $display("FAIL and_tmo: and_enable=%b err=%b busy=%b tx_pulses=%0d want 0 1 0 0",
                  bus.and_enable, bus.err, bus.busy, tx_en_cnt - t0);
      end
   endtask

   task automatic test_reset_mid();
      int c;
      int t0;
      send_frame(8'h9A, 8'hBC);
      wait_and(c);
      do_and(1, 16'hCAFE);
      @(negedge clk);
      #2 Rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.rx_en, bus.tx_en, bus.and_enable, bus.busy, bus.err,
           bus.tx_data, bus.operand} !== 29'd0) begin
         n_fail++;
         $display("FAIL async_reset: rx_en=%b tx_en=%b busy=%b err=%b tx_data=%h op=%h want all 0",
                  bus.rx_en, bus.tx_en, bus.busy, bus.err, bus.tx_data, bus.operand);
      end
      exp_q.delete();
      t0 = tx_en_cnt;
      @(negedge clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (tx_en_cnt !== t0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: tx_pulses=%0d err=%b busy=%b want 0 0 0",
                  tx_en_cnt - t0, bus.err, bus.busy);
      end
      run_frame(8'h11, 8'h22, 16'h0F0F);
   endtask

   task automatic test_back_to_back();
      int c;
      send_frame(8'hEF, 8'hCD);
      wait_and(c);
      send_byte(8'hFF);
      n_tests++;
      if (bus.operand !== 16'hCDEF || bus.and_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_ignored: operand=%h and_enable=%b want cdef 1", bus.operand, bus.and_enable);
      end
      do_and(0, 16'h8001);
      serve_tx();
      run_frame(8'h00, 8'hFF, 16'h00FF);
   endtask

`ifdef UART_SEQ_CHECKSUM_EN
   task automatic test_checksum();
      int a0;
      a0 = and_cnt;
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h00);
      exp_q.push_back(ERR_BYTE);
      serve_tx();
      n_tests++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || and_cnt !== a0) begin
         n_fail++;
         $display("FAIL csum_bad: err=%b busy=%b and_cycles=%0d want 1 0 0",
                  bus.err, bus.busy, and_cnt - a0);
      end
      run_frame(8'h34, 8'h12, 16'hA55A);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_frame();
      test_rx_timeout();
      test_and_timeout();
      test_reset_mid();
      test_back_to_back();
`ifdef UART_SEQ_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
